// File: rtl/jtag_ir_param.sv
// jtag_ir_param: parametrised JTAG instruction register with table decode,
// forced BYPASS, private-instruction lock and sticky illegal-opcode flag.
module jtag_ir_param #(
    parameter int IR_WIDTH = 4,
    parameter int N_INST = 10,
    parameter logic [N_INST*IR_WIDTH-1:0] OPCODE_TABLE =
        {4'hB, 4'hA, 4'h9, 4'h8, 4'h4, 4'h2, 4'h3, 4'h0, 4'h1, 4'hF},
    parameter logic [N_INST-1:0] PRIVATE_MASK = 10'h3C0,
    parameter int BYPASS_IDX = 0,
    parameter int IDCODE_IDX = 4
) (
    input  logic                tck,
    input  logic                tl_reset,
    input  logic                capture_ir,
    input  logic                shift_ir,
    input  logic                update_ir,
    input  logic                tdi,
    output logic                tdo,
    input  logic [IR_WIDTH-3:0] status_in,
    input  logic                priv_unlock,
    input  logic                illegal_clr,
    output logic [N_INST-1:0]   instructions,
    output logic [IR_WIDTH-1:0] inst_code,
    output logic                update_pulse,
    output logic                illegal_op
);
    localparam int IW = (N_INST > 1) ? $clog2(N_INST) : 1;
    localparam logic [IW-1:0] BYP = IW'(BYPASS_IDX);
    localparam logic [IW-1:0] IDC = IW'(IDCODE_IDX);

    logic [IR_WIDTH-1:0] r_shift;
    logic [N_INST-1:0]   r_inst;
    logic [IR_WIDTH-1:0] r_code;
    logic                r_pulse;
    logic                r_illegal;
    logic [IW-1:0]       w_match;
    logic                w_hit;
    logic [IW-1:0]       w_idx;
    logic                w_illegal;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        w_match = BYP;
        w_hit = 1'b0;
        for (int i = N_INST - 1; i >= 0; i--) begin
            if (OPCODE_TABLE[i*IR_WIDTH +: IR_WIDTH] == r_shift) begin
                w_match = IW'(i);
                w_hit = 1'b1;
            end
        end
        w_idx = BYP;
        w_illegal = 1'b1;
        if (&r_shift) begin
            w_illegal = 1'b0;
        end else if (w_hit && !(PRIVATE_MASK[w_match] && !priv_unlock)) begin
            w_idx = w_match;
            w_illegal = 1'b0;
        end
    end

    always_ff @(posedge tck) begin
        if (tl_reset) begin
            r_shift <= '0;
            r_inst <= N_INST'(1) << IDC;
            r_code <= OPCODE_TABLE[IDC*IR_WIDTH +: IR_WIDTH];
            r_pulse <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (capture_ir)
                r_shift <= {status_in, 2'b01};
            else if (shift_ir)
                r_shift <= {tdi, r_shift[IR_WIDTH-1:1]};
            r_pulse <= update_ir;
            if (update_ir) begin
                r_inst <= N_INST'(1) << w_idx;
                r_code <= OPCODE_TABLE[w_idx*IR_WIDTH +: IR_WIDTH];
            end
            if (update_ir && w_illegal)
                r_illegal <= 1'b1;
            else if (illegal_clr)
                r_illegal <= 1'b0;
        end
    end

    assign tdo = r_shift[0];
    assign instructions = r_inst;
    assign inst_code = r_code;
    assign update_pulse = r_pulse;
    assign illegal_op = r_illegal;
endmodule

// File: tb/tb_jtag_ir_param.sv
// tb_jtag_ir_param: directed test-plan sequence followed by random TAP traffic,
// every cycle checked against an arithmetic reference model of the IR.
module tb_jtag_ir_param;
    logic       tck = 1'b0;
    logic       tl_reset = 1'b0;
    logic       capture_ir = 1'b0;
    logic       shift_ir = 1'b0;
    logic       update_ir = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic [1:0] status_in = 2'b00;
    logic       priv_unlock = 1'b0;
    logic       illegal_clr = 1'b0;
    logic [9:0] instructions;
    logic [3:0] inst_code;
    logic       update_pulse;
    logic       illegal_op;

    int n_tests = 0;
    int n_fail = 0;

    int tbl [10] = '{15, 1, 0, 3, 2, 4, 8, 9, 10, 11};
    int m_sr, m_idx, m_pulse, m_ill;

    jtag_ir_param dut (
        .tck(tck), .tl_reset(tl_reset), .capture_ir(capture_ir), .shift_ir(shift_ir),
        .update_ir(update_ir), .tdi(tdi), .tdo(tdo), .status_in(status_in),
        .priv_unlock(priv_unlock), .illegal_clr(illegal_clr), .instructions(instructions),
        .inst_code(inst_code), .update_pulse(update_pulse), .illegal_op(illegal_op)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instructions 6..9 are private; all-ones is BYPASS without being illegal.
    task automatic decode(input int code, input int unl, output int idx, output int ill);
        idx = 0;
        ill = 1;
        if (code == 15) begin
            ill = 0;
            return;
        end
        for (int i = 0; i < 10; i++) begin
            if (tbl[i] == code) begin
                if (i >= 6 && unl == 0) return;
                idx = i;
                ill = 0;
                return;
            end
        end
    endtask

    task automatic step(input int cap, input int sh, input int upd, input int t,
                        input int st, input int unl, input int clr, input int rst);
        int d_idx, d_ill;
        capture_ir = 1'(cap); shift_ir = 1'(sh); update_ir = 1'(upd); tdi = 1'(t);
        status_in = 2'(st); priv_unlock = 1'(unl); illegal_clr = 1'(clr); tl_reset = 1'(rst);
        @(posedge tck);
        if (rst != 0) begin
            m_sr = 0; m_idx = 4; m_pulse = 0; m_ill = 0;
        end else begin
            decode(m_sr, unl, d_idx, d_ill);
            m_pulse = upd;
            if (upd != 0) m_idx = d_idx;
            if (upd != 0 && d_ill != 0) m_ill = 1;
            else if (clr != 0) m_ill = 0;
            if (cap != 0) m_sr = st * 4 + 1;
            else if (sh != 0) m_sr = m_sr / 2 + (t != 0 ? 8 : 0);
        end
        @(negedge tck);
        check("instructions", int'(instructions), 1 << m_idx);
        check("inst_code", int'(inst_code), tbl[m_idx]);
        check("tdo", int'(tdo), m_sr % 2);
        check("update_pulse", int'(update_pulse), m_pulse);
        check("illegal_op", int'(illegal_op), m_ill);
    endtask

    task automatic shift_code(input int code, input int unl);
        for (int i = 0; i < 4; i++) step(0, 1, 0, (code >> i) & 1, 0, unl, 0, 0);
    endtask

    initial begin
        m_sr = 0; m_idx = 4; m_pulse = 0; m_ill = 0;
        @(negedge tck);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_inst", int'(instructions), 'h010);
        check("rst_code", int'(inst_code), 2);
        check("rst_ill", int'(illegal_op), 0);
        check("rst_tdo", int'(tdo), 0);

        step(1, 0, 0, 0, 2, 0, 0, 0);
        check("cap_tdo0", int'(tdo), 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("cap_tdo1", int'(tdo), 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("cap_tdo2", int'(tdo), 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("cap_tdo3", int'(tdo), 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);

        shift_code(3, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        check("legal_inst", int'(instructions), 'h008);
        check("legal_code", int'(inst_code), 3);
        check("legal_pulse", int'(update_pulse), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("pulse_once", int'(update_pulse), 0);

        shift_code(12, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        check("unmatched_inst", int'(instructions), 'h001);
        check("unmatched_ill", int'(illegal_op), 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("clr_ill", int'(illegal_op), 0);
        shift_code(15, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        check("ones_inst", int'(instructions), 'h001);
        check("ones_ill", int'(illegal_op), 0);

        shift_code(8, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        check("locked_inst", int'(instructions), 'h001);
        check("locked_ill", int'(illegal_op), 1);
        step(0, 0, 1, 0, 0, 1, 0, 0);
        check("unlocked_inst", int'(instructions), 'h040);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("hold_inst", int'(instructions), 'h040);

        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        check("midrst_inst", int'(instructions), 'h010);
        check("midrst_tdo", int'(tdo), 0);

        shift_code(12, 0);
        step(0, 0, 1, 0, 0, 0, 1, 0);
        check("set_wins", int'(illegal_op), 1);

        shift_code(3, 0);
        step(0, 1, 1, 1, 0, 0, 0, 0);
        check("upd_shift_inst", int'(instructions), 'h008);

        for (int n = 0; n < 600; n++) begin
            step(($urandom % 8) == 0, $urandom % 2, ($urandom % 5) == 0, $urandom % 2,
                 $urandom % 4, $urandom % 2, ($urandom % 8) == 0, ($urandom % 50) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
